wiscsc15_mem_arb: RTL and testbench



---
 rtl/wiscsc15_pkg.sv | 25 ++
 rtl/wiscsc15_timeout_ctr.sv | 35 +++
 rtl/wiscsc15_mem_arb.sv | 186 ++++++++++++++++++
 tb/tb_wiscsc15_mem_arb.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wiscsc15_pkg.sv
// Shared definitions for the WISC-SC15 memory sequencing logic.
// Holds the arbiter state encoding, the transaction owner encoding and the
// memory-side defaults shared with the control unit.
package wiscsc15_pkg;

    // Arbiter sequencing states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_DONE  = 2'b11
    } arb_state_e;

    // Which requester owns the transaction in flight
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_e;

    // Memory-side defaults shared with the control unit
    localparam int MEM_AW      = 16;
    localparam int MEM_DW      = 16;
    localparam int MEM_TIMEOUT = 255;

endpackage

// File: rtl/wiscsc15_timeout_ctr.sv
// Response timeout counter for the memory arbiter.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   clr      : load zero (has priority over en)
//   en       : count up by one
//   tc       : count has reached TIMEOUT-1
module wiscsc15_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    // TIMEOUT-1 always fits in clog2(TIMEOUT) bits for TIMEOUT >= 2
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    logic [CW-1:0] count_r;

    // Count register: reset/clear to zero, otherwise advance while enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (clr) begin
            count_r <= {CW{1'b0}};
        end else if (en) begin
            count_r <= count_r + CW'(1);
        end
    end

    assign tc = (count_r == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wiscsc15_mem_arb.sv
// Single-port unified memory arbiter/sequencer for the WISC-SC15 core.
// Accepts one request (data port has priority over fetch), issues a one-cycle
// mem_en strobe, waits for a variable-latency mem_valid (or times out), then
// returns data and a one-cycle done pulse to the owner.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   if_req/if_addr/if_rdata/if_done  : instruction fetch port
//   dm_read/dm_write/dm_addr/dm_wdata/dm_rdata/dm_done : data port
//   stall_if/stall_dm                : pipeline freeze (combinational)
//   mem_en/mem_wr/mem_addr/mem_wdata : registered memory command
//   mem_rdata/mem_valid              : memory response
//   err                              : sticky error (timeout or read&write)
module wiscsc15_mem_arb
    import wiscsc15_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          dm_read,
    input  logic          dm_write,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_done,
    output logic          stall_if,
    output logic          stall_dm,
    output logic          mem_en,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_valid,
    output logic          err
);

    arb_state_e    state_r;
    arb_state_e    state_s;
    owner_e        owner_r;
    logic          mem_en_r;
    logic          mem_wr_r;
    logic [AW-1:0] mem_addr_r;
    logic [DW-1:0] mem_wdata_r;
    logic [DW-1:0] if_rdata_r;
    logic [DW-1:0] dm_rdata_r;
    logic          if_done_r;
    logic          dm_done_r;
    logic          err_r;
    logic          dm_req_s;
    logic          ctr_clr_s;
    logic          ctr_en_s;
    logic          tc_s;

    assign dm_req_s  = dm_read | dm_write;
    assign ctr_clr_s = (state_r == ST_ISSUE);
    assign ctr_en_s  = (state_r == ST_WAIT) & ~mem_valid;

    wiscsc15_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk (clk),
        .rst (rst),
        .clr (ctr_clr_s),
        .en  (ctr_en_s),
        .tc  (tc_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; DONE always returns to IDLE so a held request
    // has one cycle to drop before it could be accepted again
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (dm_req_s || if_req) begin
                    state_s = ST_ISSUE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_s = ST_WAIT;
            ST_WAIT: begin
                if (mem_valid || tc_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Request latching, memory command and response/holding registers
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_r     <= OWN_IF;
            mem_en_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            mem_wdata_r <= {DW{1'b0}};
            if_rdata_r  <= {DW{1'b0}};
            dm_rdata_r  <= {DW{1'b0}};
            if_done_r   <= 1'b0;
            dm_done_r   <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            mem_en_r  <= 1'b0;
            if_done_r <= 1'b0;
            dm_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (dm_req_s) begin
                        // read&write together is resolved as a write
                        owner_r     <= OWN_DM;
                        mem_wr_r    <= dm_write;
                        mem_addr_r  <= dm_addr;
                        mem_wdata_r <= dm_wdata;
                        mem_en_r    <= 1'b1;
                        if (dm_read && dm_write) begin
                            err_r <= 1'b1;
                        end
                    end else if (if_req) begin
                        owner_r    <= OWN_IF;
                        mem_wr_r   <= 1'b0;
                        mem_addr_r <= if_addr;
                        mem_en_r   <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (mem_valid) begin
                        if (owner_r == OWN_IF) begin
                            if_rdata_r <= mem_rdata;
                            if_done_r  <= 1'b1;
                        end else begin
                            if (!mem_wr_r) begin
                                dm_rdata_r <= mem_rdata;
                            end
                            dm_done_r <= 1'b1;
                        end
                    end else if (tc_s) begin
                        err_r <= 1'b1;
                        if (owner_r == OWN_IF) begin
                            if_rdata_r <= {DW{1'b0}};
                            if_done_r  <= 1'b1;
                        end else begin
                            if (!mem_wr_r) begin
                                dm_rdata_r <= {DW{1'b0}};
                            end
                            dm_done_r <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_en    = mem_en_r;
    assign mem_wr    = mem_wr_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign if_rdata  = if_rdata_r;
    assign dm_rdata  = dm_rdata_r;
    assign if_done   = if_done_r;
    assign dm_done   = dm_done_r;
    assign err       = err_r;
    assign stall_if  = if_req & ~if_done_r;
    assign stall_dm  = dm_req_s & ~dm_done_r;

endmodule

// File: tb/tb_wiscsc15_mem_arb.sv
// Scoreboard bench for wiscsc15_mem_arb: stimulus pushes expected memory
// commands and completions; a monitor pops and compares them when the DUT
// presents mem_en or a done pulse.
module tb_wiscsc15_mem_arb;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          dm_read;
    logic          dm_write;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          stall_if;
    logic          stall_dm;
    logic          mem_en;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;
    logic          err;

    wiscsc15_mem_arb #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .stall_if(stall_if), .stall_dm(stall_dm),
        .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } mem_exp_t;

    typedef struct {
        bit            is_dm;
        logic [DW-1:0] rdata;
        logic          err;
    } done_exp_t;

    mem_exp_t  exp_mem[$];
    done_exp_t exp_done[$];

    int n_cmp    = 0;
    int n_fail   = 0;
    int n_mem_en = 0;
    int lat      = 1;   // mem_valid delay after mem_en; 0 = never respond

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_lookup(input logic [AW-1:0] a);
        case (a)
            16'h0040: mem_lookup = 16'hB123;
            16'h1000: mem_lookup = 16'h00FF;
            16'h4000: mem_lookup = 16'h5555;
            default:  mem_lookup = a ^ 16'h5A5A;
        endcase
    endfunction

    // Memory model: one-cycle mem_valid lat cycles after the mem_en cycle
    initial begin
        int cnt;
        cnt = 0;
        mem_valid = 1'b0;
        mem_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            mem_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) mem_valid = 1'b1;
            end
            if (mem_en && lat > 0) begin
                cnt = lat;
                mem_rdata = mem_lookup(mem_addr);
            end
        end
    end

    // Monitor: compares every memory command and completion against the queues
    initial begin
        mem_exp_t  m;
        done_exp_t d;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_en) begin
                    n_mem_en++;
                    if (exp_mem.size() == 0) begin
                        check("unexpected_mem_en", 32'd1, 32'd0);
                    end else begin
                        m = exp_mem.pop_front();
                        check("mem_wr", {31'd0, mem_wr}, {31'd0, m.wr});
                        check("mem_addr", {16'd0, mem_addr}, {16'd0, m.addr});
                        if (m.wr) check("mem_wdata", {16'd0, mem_wdata}, {16'd0, m.wdata});
                    end
                end
                if (if_done || dm_done) begin
                    if (exp_done.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        d = exp_done.pop_front();
                        check("done_port_is_dm", {31'd0, dm_done}, {31'd0, d.is_dm});
                        check("done_port_not_if", {31'd0, if_done}, {31'd0, ~d.is_dm});
                        if (d.is_dm) check("dm_rdata", {16'd0, dm_rdata}, {16'd0, d.rdata});
                        else         check("if_rdata", {16'd0, if_rdata}, {16'd0, d.rdata});
                        check("err_at_done", {31'd0, err}, {31'd0, d.err});
                    end
                end
            end
        end
    end

    // Wait for a port's done pulse, checking stall along the way
    task automatic wait_done(input bit is_dm, input int max_cyc, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < max_cyc) begin
            @(negedge clk);
            cyc++;
            if (is_dm ? dm_done : if_done) begin
                seen = 1'b1;
                check(is_dm ? "stall_dm_at_done" : "stall_if_at_done",
                      {31'd0, is_dm ? stall_dm : stall_if}, 32'd0);
            end else begin
                check(is_dm ? "stall_dm_busy" : "stall_if_busy",
                      {31'd0, is_dm ? stall_dm : stall_if}, 32'd1);
            end
        end
        if (!seen) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: no done pulse within %0d cycles", is_dm ? "dm_done" : "if_done", max_cyc);
        end
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = 16'h0000;
        dm_read = 1'b0; dm_write = 1'b0; dm_addr = 16'h0000; dm_wdata = 16'h0000;
    endtask

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        int cyc;
        int en_base;
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mem_en", {31'd0, mem_en}, 32'd0);
        check("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        check("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
        check("rst_if_rdata", {16'd0, if_rdata}, 32'd0);
        check("rst_dm_rdata", {16'd0, dm_rdata}, 32'd0);
        check("rst_dones", {30'd0, if_done, dm_done}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Fetch only, memory answers two cycles after mem_en
        #1;
        lat = 2;
        exp_mem.push_back('{wr: 1'b0, addr: 16'h0040, wdata: 16'h0000});
        exp_done.push_back('{is_dm: 1'b0, rdata: 16'hB123, err: 1'b0});
        if_req = 1'b1; if_addr = 16'h0040;
        wait_done(1'b0, TO + 10, cyc);
        check("fetch_latency", cyc, 32'd5);
        @(posedge clk); #1;
        if_req = 1'b0;
        repeat (2) @(posedge clk);

        // Contention: DM wins, IF follows after DONE->IDLE
        #1;
        lat = 1;
        en_base = n_mem_en;
        exp_mem.push_back('{wr: 1'b0, addr: 16'h1000, wdata: 16'h0000});
        exp_mem.push_back('{wr: 1'b0, addr: 16'h0040, wdata: 16'h0000});
        exp_done.push_back('{is_dm: 1'b1, rdata: 16'h00FF, err: 1'b0});
        exp_done.push_back('{is_dm: 1'b0, rdata: 16'hB123, err: 1'b0});
        if_req = 1'b1; if_addr = 16'h0040;
        dm_read = 1'b1; dm_addr = 16'h1000;
        wait_done(1'b1, TO + 10, cyc);
        check("dm_latency", cyc, 32'd4);
        check("stall_if_during_dm", {31'd0, stall_if}, 32'd1);
        check("if_rdata_held", {16'd0, if_rdata}, 32'h0000B123);
        @(posedge clk); #1;
        dm_read = 1'b0;
        wait_done(1'b0, TO + 10, cyc);
        check("if_after_dm_latency", cyc, 32'd4);
        @(posedge clk); #1;
        if_req = 1'b0;
        repeat (2) @(posedge clk);
        check("contention_mem_en_count", n_mem_en - en_base, 32'd2);

        // Write: dm_rdata must keep its previous read value
        #1;
        exp_mem.push_back('{wr: 1'b1, addr: 16'h2002, wdata: 16'hCAFE});
        exp_done.push_back('{is_dm: 1'b1, rdata: 16'h00FF, err: 1'b0});
        dm_write = 1'b1; dm_addr = 16'h2002; dm_wdata = 16'hCAFE;
        wait_done(1'b1, TO + 10, cyc);
        @(posedge clk); #1;
        dm_write = 1'b0;
        repeat (2) @(posedge clk);

        // Timeout: memory never answers
        #1;
        lat = 0;
        exp_mem.push_back('{wr: 1'b0, addr: 16'h3000, wdata: 16'h0000});
        exp_done.push_back('{is_dm: 1'b1, rdata: 16'h0000, err: 1'b1});
        dm_read = 1'b1; dm_addr = 16'h3000;
        wait_done(1'b1, TO + 10, cyc);
        check("timeout_latency", cyc, TO + 3);
        @(posedge clk); #1;
        dm_read = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("err_sticky", {31'd0, err}, 32'd1);

        // Reset during WAIT, late response afterwards must be ignored
        @(posedge clk); #1;
        lat = 4;
        exp_mem.push_back('{wr: 1'b0, addr: 16'h4000, wdata: 16'h0000});
        dm_read = 1'b1; dm_addr = 16'h4000;
        repeat (3) @(negedge clk);   // IDLE, ISSUE, WAIT
        rst = 1'b1;
        dm_read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        check("rstwait_if_rdata", {16'd0, if_rdata}, 32'd0);
        check("rstwait_dm_rdata", {16'd0, dm_rdata}, 32'd0);
        check("rstwait_err", {31'd0, err}, 32'd0);
        check("rstwait_dones", {30'd0, if_done, dm_done}, 32'd0);

        // Illegal read & write together: handled as a write, flags err
        @(posedge clk); #1;
        lat = 1;
        exp_mem.push_back('{wr: 1'b1, addr: 16'h5000, wdata: 16'h1234});
        exp_done.push_back('{is_dm: 1'b1, rdata: 16'h0000, err: 1'b1});
        dm_read = 1'b1; dm_write = 1'b1; dm_addr = 16'h5000; dm_wdata = 16'h1234;
        wait_done(1'b1, TO + 10, cyc);
        @(posedge clk); #1;
        dm_read = 1'b0; dm_write = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("illegal_err", {31'd0, err}, 32'd1);

        check("exp_mem_drained", exp_mem.size(), 32'd0);
        check("exp_done_drained", exp_done.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
